branch_sequencer: RTL

Multi-cycle controller that sequences one conditional branch through the shared ALU compare path and the branch-condition select mux.
- Accepts a branch request.
- Launches an ALU subtract and drives the 2-bit branch-condition select.
- Waits for the ALU result and samples the mux output.
- Issues a single-cycle conditional PC-write pulse and reports the outcome.
- Sits between the main control FSM and the PC-write condition logic; keeps taken/not-taken statistics.

---
 rtl/mips_ctrl_pkg.sv | 26 ++
 rtl/sat_counter.sv | 26 ++
 rtl/branch_sequencer.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared control encodings for the branch sequencer
//
// Purpose: state encoding, branch-condition select codes and ALU opcodes
// shared between the main control path and the branch sequencer.
// Ports: none (package).
package mips_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ALU_REQ  = 3'd1,
        S_ALU_WAIT = 3'd2,
        S_PC_WRITE = 3'd3,
        S_ERR      = 3'd4
    } br_state_t;

    // Branch-condition mux selects
    localparam logic [1:0] BR_EQ  = 2'b00;
    localparam logic [1:0] BR_GT  = 2'b01;
    localparam logic [1:0] BR_LEZ = 2'b10;
    localparam logic [1:0] BR_NE  = 2'b11;

    // ALU operation codes
    localparam logic [2:0] ALU_NOP = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b010;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - width-parameterised saturating incrementer with enable
//
// Purpose: counts enabled cycles and sticks at all-ones.
// Ports:
//   clk   - clock, rising edge
//   reset - synchronous active-high clear
//   en    - increment this cycle
//   count - current count
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (en && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/branch_sequencer.sv
// rtl/branch_sequencer.sv - multi-cycle conditional branch sequencer
//
// Purpose: accepts a branch request, launches an ALU compare, samples the
// branch-condition mux, issues a one-cycle PC-write pulse and keeps
// taken/not-taken statistics.
// Ports:
//   clk, reset                 - clock and synchronous active-high reset
//   flush                      - abort any in-flight branch
//   br_valid/br_ready/br_type  - branch request handshake and condition type
//   alu_start/alu_op/alu_done  - ALU compare launch, opcode and completion
//   branch_ctrl/branch_cond    - condition mux select and its output
//   pc_write_cond              - one-cycle PC write pulse
//   resp_valid/resp_taken/resp_err - completion pulse and outcome
//   taken_cnt/not_taken_cnt    - saturating statistics
module branch_sequencer
    import mips_ctrl_pkg::*;
#(
    parameter logic [2:0] ALU_SUB_OP = ALU_SUB,
    parameter int         CNT_W      = 16,
    parameter int         TIMEOUT    = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             br_valid,
    output logic             br_ready,
    input  logic [1:0]       br_type,
    output logic             alu_start,
    output logic [2:0]       alu_op,
    input  logic             alu_done,
    output logic [1:0]       branch_ctrl,
    input  logic             branch_cond,
    output logic             pc_write_cond,
    output logic             resp_valid,
    output logic             resp_taken,
    output logic             resp_err,
    output logic [CNT_W-1:0] taken_cnt,
    output logic [CNT_W-1:0] not_taken_cnt
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    br_state_t         state, state_nxt;
    logic [1:0]        type_q;
    logic              taken_q;
    logic [WAIT_W-1:0] wait_cnt;
    logic              wait_hit;
    logic              accept;
    logic              inc_taken, inc_not_taken;

    // wait_cnt counts completed idle ALU_WAIT cycles; the cycle that would
    // bring it to TIMEOUT is the last one we tolerate.
    assign wait_hit = (wait_cnt == WAIT_W'(TIMEOUT - 1));
    assign accept   = (state == S_IDLE) && br_valid && !flush;

    // type_q only changes on accept, so it naturally holds its last value
    // through IDLE and ERR.
    assign branch_ctrl = type_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            type_q   <= 2'b00;
            taken_q  <= 1'b0;
            wait_cnt <= '0;
        end else begin
            if (accept) begin
                type_q <= br_type;
            end
            if (state == S_ALU_REQ) begin
                wait_cnt <= '0;
            end else if ((state == S_ALU_WAIT) && !alu_done) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end
            if ((state == S_ALU_WAIT) && alu_done && !flush) begin
                taken_q <= branch_cond;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:     if (accept) state_nxt = S_ALU_REQ;
            S_ALU_REQ:  state_nxt = S_ALU_WAIT;
            S_ALU_WAIT: begin
                // alu_done has priority over the timeout
                if (alu_done)      state_nxt = S_PC_WRITE;
                else if (wait_hit) state_nxt = S_ERR;
            end
            S_PC_WRITE: state_nxt = S_IDLE;
            S_ERR:      state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
        if (flush) begin
            state_nxt = S_IDLE;
        end
    end

    always_comb begin
        br_ready      = 1'b0;
        alu_start     = 1'b0;
        alu_op        = ALU_NOP;
        pc_write_cond = 1'b0;
        resp_valid    = 1'b0;
        resp_taken    = 1'b0;
        resp_err      = 1'b0;
        case (state)
            S_IDLE:     br_ready = !flush;
            S_ALU_REQ: begin
                alu_start = 1'b1;
                alu_op    = ALU_SUB_OP;
            end
            S_ALU_WAIT: alu_op = ALU_SUB_OP;
            S_PC_WRITE: begin
                if (!flush) begin
                    pc_write_cond = taken_q;
                    resp_valid    = 1'b1;
                    resp_taken    = taken_q;
                end
            end
            S_ERR: begin
                if (!flush) begin
                    resp_valid = 1'b1;
                    resp_err   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign inc_taken     = (state == S_PC_WRITE) && !flush &&  taken_q;
    assign inc_not_taken = (state == S_PC_WRITE) && !flush && !taken_q;

    sat_counter #(.W(CNT_W)) u_taken_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (inc_taken),
        .count (taken_cnt)
    );

    sat_counter #(.W(CNT_W)) u_not_taken_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (inc_not_taken),
        .count (not_taken_cnt)
    );

endmodule
